// File: rtl/add_order_to_book.sv
`default_nettype none
// ============================================================================
// Module   : add_order_to_book
// Purpose  : Inserts one order into the buy or sell order-book RAM. Scans the
//            selected side from address 0 for the first all-zero slot and
//            writes the packed {order_id, quantity, limit} word there, so the
//            book stays contiguous for the stop-at-first-zero scanner.
//            Rejects the order when the side is full or the quantity is zero.
// Revision : 1.0  initial release
// ============================================================================
module add_order_to_book #(
    parameter int MAX_BOOK_SIZE = 10,
    parameter int ADDR_W        = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              side,
    input  logic [15:0]       limit,
    input  logic [15:0]       quantity,
    input  logic [15:0]       order_id,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [47:0]       ram_wdata,
    output logic              buy_wren,
    output logic              sell_wren,
    input  logic [47:0]       buy_rdata,
    input  logic [47:0]       sell_rdata,
    output logic [ADDR_W-1:0] slot,
    output logic              ok,
    output logic              done
);

    // Last slot index; the scan index is compared against it before it is
    // incremented, so it never walks past the end of the book.
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(MAX_BOOK_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_WRITE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_idx;
    logic               r_side;
    logic [47:0]        r_word;
    logic [47:0]        r_wdata;
    logic               r_buy_wren;
    logic               r_sell_wren;
    logic [ADDR_W-1:0]  r_slot;
    logic               r_ok;
    logic               r_done;

    logic [47:0]        w_sel_rdata;
    logic               w_slot_empty;

    // The latched side picks which RAM's read data the scan looks at.
    assign w_sel_rdata  = r_side ? sell_rdata : buy_rdata;
    assign w_slot_empty = (w_sel_rdata == 48'd0);

    // The scan index drives the shared RAM address directly; it is a register,
    // and it is held at 0 whenever no request is in progress.
    assign ram_addr  = r_idx;
    assign ram_wdata = r_wdata;
    assign buy_wren  = r_buy_wren;
    assign sell_wren = r_sell_wren;
    assign slot      = r_slot;
    assign ok        = r_ok;
    assign done      = r_done;

    // Request sequencer: latch order, scan for the first free slot, write once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_side      <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_buy_wren  <= 1'b0;
            r_sell_wren <= 1'b0;
            r_slot      <= '0;
            r_ok        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // The order is captured here so that later input
                        // changes cannot disturb the request in flight.
                        r_idx   <= '0;
                        r_side  <= side;
                        r_word  <= {order_id, quantity, limit};
                        r_state <= S_LATCH;
                    end
                end

                S_LATCH: begin
                    if (r_word[31:16] == 16'd0) begin
                        r_ok    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_READ;
                    end
                end

                // Address is presented during READ; the RAM registers it.
                S_READ: r_state <= S_WAIT;

                // One more cycle so the registered RAM output is settled.
                S_WAIT: r_state <= S_CHECK;

                S_CHECK: begin
                    if (w_slot_empty) begin
                        r_wdata     <= r_word;
                        r_buy_wren  <= ~r_side;
                        r_sell_wren <= r_side;
                        r_state     <= S_WRITE;
                    end else if (r_idx == c_last_idx) begin
                        r_ok    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_READ;
                    end
                end

                S_WRITE: begin
                    r_buy_wren  <= 1'b0;
                    r_sell_wren <= 1'b0;
                    r_wdata     <= '0;
                    r_slot      <= r_idx;
                    r_ok        <= 1'b1;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    // A held start must drop before another request is taken.
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_ok    <= 1'b0;
                        r_slot  <= '0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_add_order_to_book.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_order_to_book
// Purpose  : Self-checking bench for add_order_to_book. Two registered-output
//            RAM models stand in for the order books; a reference book model
//            predicts each outcome, a scoreboard queue carries the prediction
//            to a monitor that checks it when done rises.
// Revision : 1.0  initial release
// ============================================================================
module tb_add_order_to_book;

    localparam int MAX = 10;
    localparam int AW  = 12;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          start    = 1'b0;
    logic          side     = 1'b0;
    logic [15:0]   limit    = '0;
    logic [15:0]   quantity = '0;
    logic [15:0]   order_id = '0;
    logic [AW-1:0] ram_addr;
    logic [47:0]   ram_wdata;
    logic          buy_wren;
    logic          sell_wren;
    logic [47:0]   buy_rdata;
    logic [47:0]   sell_rdata;
    logic [AW-1:0] slot;
    logic          ok;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    add_order_to_book #(.MAX_BOOK_SIZE(MAX), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .side       (side),
        .limit      (limit),
        .quantity   (quantity),
        .order_id   (order_id),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .buy_wren   (buy_wren),
        .sell_wren  (sell_wren),
        .buy_rdata  (buy_rdata),
        .sell_rdata (sell_rdata),
        .slot       (slot),
        .ok         (ok),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure request latency.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- book RAM models (1-clk registered read) ----------------
    logic [47:0] buy_mem  [16];
    logic [47:0] sell_mem [16];
    logic        pre_we   = 1'b0;
    logic        pre_clr  = 1'b0;
    logic        pre_side = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [47:0] pre_data = '0;

    // RAM read/write plus a bench-side port for clearing and preloading books.
    always @(posedge clk) begin
        buy_rdata  <= buy_mem[ram_addr[3:0]];
        sell_rdata <= sell_mem[ram_addr[3:0]];
        if (buy_wren)  buy_mem[ram_addr[3:0]]  <= ram_wdata;
        if (sell_wren) sell_mem[ram_addr[3:0]] <= ram_wdata;
        if (pre_clr) begin
            for (int k = 0; k < 16; k++) begin
                if (pre_side) sell_mem[k] <= '0;
                else          buy_mem[k]  <= '0;
            end
        end
        if (pre_we) begin
            if (pre_side) sell_mem[pre_addr] <= pre_data;
            else          buy_mem[pre_addr]  <= pre_data;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [47:0] ref_book [2][MAX];

    typedef struct {
        logic          ok;
        logic [AW-1:0] slot;
        logic          side;
        logic [47:0]   word;
        int            lat;
        int            start_cyc;
    } exp_t;

    exp_t q_exp[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endfunction

    // First empty slot of a side, or -1 when every slot holds an order.
    function automatic int find_free(input logic s);
        for (int k = 0; k < MAX; k++)
            if (ref_book[s][k] == 48'd0) return k;
        return -1;
    endfunction

    // ---------------- monitor ----------------
    int            wr_cnt   = 0;
    int            total_wr = 0;
    logic          wr_side  = 1'b0;
    logic [AW-1:0] wr_addr  = '0;
    logic [47:0]   wr_data  = '0;
    logic          prev_done = 1'b0;
    exp_t          mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (buy_wren || sell_wren) begin
                chk("wren_one_side", 64'(buy_wren & sell_wren), 64'd0);
                chk("wren_addr_in_range", 64'(ram_addr < AW'(MAX)), 64'd1);
                wr_cnt++;
                total_wr++;
                wr_side = sell_wren;
                wr_addr = ram_addr;
                wr_data = ram_wdata;
            end
            if (done && !prev_done) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = q_exp.pop_front();
                    chk("ok", 64'(ok), 64'(mon_e.ok));
                    chk("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
                    chk("write_count", 64'(wr_cnt), mon_e.ok ? 64'd1 : 64'd0);
                    if (mon_e.ok) begin
                        chk("slot", 64'(slot), 64'(mon_e.slot));
                        if (wr_cnt == 1) begin
                            chk("write_side", 64'(wr_side), 64'(mon_e.side));
                            chk("write_addr", 64'(wr_addr), 64'(mon_e.slot));
                            chk("write_data", 64'(wr_data), 64'(mon_e.word));
                        end
                    end
                end
                wr_cnt = 0;
            end
            prev_done = done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side(input logic s);
        pre_side = s;
        pre_clr  = 1'b1;
        tick();
        pre_clr  = 1'b0;
        for (int k = 0; k < MAX; k++) ref_book[s][k] = '0;
    endtask

    task automatic preload(input logic s, input int k, input logic [47:0] w);
        pre_side = s;
        pre_addr = 4'(k);
        pre_data = w;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
        ref_book[s][k] = w;
    endtask

    // Side s becomes a contiguous book of n occupied (non-zero quantity) slots.
    task automatic fill(input logic s, input int n);
        clear_side(s);
        for (int k = 0; k < n; k++)
            preload(s, k, {16'($urandom), 16'($urandom) | 16'd1, 16'($urandom)});
    endtask

    task automatic compare_books();
        for (int k = 0; k < MAX; k++) begin
            chk("buy_book", 64'(buy_mem[k]), 64'(ref_book[0][k]));
            chk("sell_book", 64'(sell_mem[k]), 64'(ref_book[1][k]));
        end
    endtask

    // Issue one order, predict its outcome, hold start for 'hold' cycles in DONE.
    task automatic do_order(input logic s, input logic [15:0] id, input logic [15:0] q,
                            input logic [15:0] lim, input int hold);
        exp_t e;
        int   k;
        int   n;
        e.side = s;
        e.word = {id, q, lim};
        e.ok   = 1'b0;
        e.slot = '0;
        k = find_free(s);
        if (q == 16'd0) begin
            e.lat = 2;
        end else if (k < 0) begin
            e.lat = 2 + 3 * MAX;
        end else begin
            e.ok  = 1'b1;
            e.slot = AW'(k);
            e.lat = 6 + 3 * k;
            ref_book[s][k] = e.word;
        end
        side     = s;
        order_id = id;
        quantity = q;
        limit    = lim;
        start    = 1'b1;
        e.start_cyc = cyc;
        q_exp.push_back(e);
        tick();
        tick();
        // Inputs wander once the order is captured; the result must not move.
        side     = 1'($urandom);
        order_id = 16'($urandom);
        quantity = 16'($urandom);
        limit    = 16'($urandom);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk("done_timeout", 64'(done), 64'd1);
            q_exp.delete();
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("done_held", 64'(done), 64'd1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        tick();
        chk("done_fall", 64'(done), 64'd0);
        chk("ok_clear", 64'(ok), 64'd0);
        chk("slot_clear", 64'(slot), 64'd0);
        compare_books();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   w;
        logic s;
        logic [15:0] q;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr", 64'(ram_addr), 64'd0);
        chk("reset_wdata", 64'(ram_wdata), 64'd0);
        chk("reset_wren", 64'({buy_wren, sell_wren}), 64'd0);
        chk("reset_slot", 64'(slot), 64'd0);
        chk("reset_ok", 64'(ok), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst = 1'b1;
        clear_side(1'b0);
        clear_side(1'b1);
        chk("idle_done", 64'(done), 64'd0);

        // Empty buy book: first order lands in slot 0.
        do_order(1'b0, 16'd1, 16'd100, 16'd500, 0);
        chk("scanner_volume", 64'(buy_mem[0][31:16]), 64'd100);

        // Sell slots 0-2 occupied: order lands in slot 3.
        fill(1'b1, 3);
        do_order(1'b1, 16'd7, 16'd40, 16'd250, 0);

        // Full buy book: rejected, nothing written.
        fill(1'b0, MAX);
        do_order(1'b0, 16'd3, 16'd5, 16'd6, 0);

        // Zero quantity: rejected straight from the latch step.
        clear_side(1'b0);
        do_order(1'b0, 16'd4, 16'd0, 16'd9, 0);

        // Start held through DONE: still exactly one write.
        do_order(1'b0, 16'd5, 16'd6, 16'd7, 4);

        // Reset during the scan at slot 2 aborts the request.
        fill(1'b0, 6);
        side     = 1'b0;
        order_id = 16'd9;
        quantity = 16'd5;
        limit    = 16'd3;
        start    = 1'b1;
        repeat (8) tick();
        chk("scan_at_slot2", 64'(ram_addr), 64'd2);
        start = 1'b0;
        w = total_wr;
        #3;
        rst = 1'b0;
        #1;
        chk("abort_addr", 64'(ram_addr), 64'd0);
        chk("abort_wren", 64'({buy_wren, sell_wren}), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ok", 64'(ok), 64'd0);
        chk("abort_slot", 64'(slot), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("abort_no_write", 64'(total_wr), 64'(w));
        chk("abort_stays_idle", 64'(done), 64'd0);
        compare_books();
        // A fresh request after the abort runs the full scan from slot 0.
        do_order(1'b0, 16'd11, 16'd12, 16'd13, 0);

        // Randomized orders; books fill up naturally and hit the full case.
        for (int t = 0; t < 30; t++) begin
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) fill(s, int'($urandom_range(0, MAX)));
            q = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            do_order(s, 16'($urandom), q, 16'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        chk("scoreboard_drained", 64'(q_exp.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected to have finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
